// File: rtl/in_shift_pkg.sv
// Shared types and constants for the input shift register sequencer.
package in_shift_pkg;

    localparam int unsigned N1_DEF = 102;   // bits per lane
    localparam int unsigned N2_DEF = 6;     // lane count

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_HOLD  = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HOLD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Register mode select {SelShift,SelKeep} driven while in a given state
    function automatic logic [1:0] mode_of(input state_e s);
        logic [1:0] m;
        m = MODE_HOLD;
        case (s)
            LOAD:    m = MODE_LOAD;
            SHIFT:   m = MODE_SHIFT;
            default: m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/in_shift_bitcnt.sv
// Terminal-count counter shared by the LOAD and SHIFT phases.
module in_shift_bitcnt #(
    parameter int unsigned CW = 7
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [CW-1:0] i_term,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc_c
);

    logic [CW-1:0] r_cnt;

    // Terminal flag: counter sits on the programmed last value
    assign o_tc_c = (r_cnt == i_term);
    assign o_cnt  = r_cnt;

    // Count up while enabled, wrap to zero after the terminal value
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc_c ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/in_shift_ctrl.sv
// Frame sequencer for the N2-lane x N1-bit input shift register:
// serial load, held frame with valid/ack handshake, optional shift-out.
// Optional frame counter output enabled by IN_SHIFT_CTRL_FRMCNT_EN.
module in_shift_ctrl
    import in_shift_pkg::*;
#(
    parameter  int unsigned N1 = N1_DEF,
    localparam int unsigned CW = $clog2(N1 + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_ack,
    input  logic [CW-1:0] i_shift_len,
    output logic          o_sel_shift,
    output logic          o_sel_keep,
    output logic          o_busy,
    output logic          o_frame_valid,
    output logic          o_done,
    output logic [CW-1:0] o_bit_cnt
`ifdef IN_SHIFT_CTRL_FRMCNT_EN
    ,
    output logic [15:0]   o_frame_cnt
`endif
);

    state_e        r_state;
    state_e        w_state_next;
    logic [CW-1:0] r_len;
    logic [CW-1:0] w_len_clip;
    logic [CW-1:0] w_term;
    logic [CW-1:0] w_cnt;
    logic          w_tc;
    logic          w_clr;
    logic          w_en;
    logic [1:0]    w_mode_next;
    logic          w_busy_next;
    logic          w_fv_next;
    logic          w_done_next;
    logic          r_sel_shift;
    logic          r_sel_keep;
    logic          r_busy;
    logic          r_fv;
    logic          r_done;

    // Requested shift length clipped to the lane width
    assign w_len_clip = (i_shift_len > CW'(N1)) ? CW'(N1) : i_shift_len;

    // Counter runs in LOAD/SHIFT and restarts on every state change
    assign w_term = (r_state == SHIFT) ? (r_len - CW'(1)) : CW'(N1 - 1);
    assign w_en   = (r_state == LOAD) || (r_state == SHIFT);
    assign w_clr  = (w_state_next != r_state);

    in_shift_bitcnt #(
        .CW (CW)
    ) u_bitcnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_term (w_term),
        .o_cnt  (w_cnt),
        .o_tc_c (w_tc)
    );

    // State register with registered Moore outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sel_shift <= 1'b0;
            r_sel_keep  <= 1'b1;
            r_busy      <= 1'b0;
            r_fv        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sel_shift <= w_mode_next[1];
            r_sel_keep  <= w_mode_next[0];
            r_busy      <= w_busy_next;
            r_fv        <= w_fv_next;
            r_done      <= w_done_next;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = LOAD;
            LOAD:    if (w_tc) w_state_next = HOLD;
            HOLD:    if (i_ack) w_state_next = (r_len != '0) ? SHIFT : DONE;
            SHIFT:   if (w_tc) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (i_abort) begin
            w_state_next = IDLE;
        end
    end

    // Output decode of the state being entered
    always_comb begin
        w_mode_next = mode_of(w_state_next);
        w_busy_next = (w_state_next != IDLE);
        w_fv_next   = (w_state_next == HOLD);
        w_done_next = (w_state_next == DONE);
    end

    // Shift length captured only when a frame is accepted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len <= '0;
        end else if ((r_state == IDLE) && (w_state_next == LOAD)) begin
            r_len <= w_len_clip;
        end
    end

    assign o_sel_shift   = r_sel_shift;
    assign o_sel_keep    = r_sel_keep;
    assign o_busy        = r_busy;
    assign o_frame_valid = r_fv;
    assign o_done        = r_done;
    assign o_bit_cnt     = w_cnt;

`ifdef IN_SHIFT_CTRL_FRMCNT_EN
    logic [15:0] r_frame_cnt;

    // Completed-frame counter, advanced together with the Done pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
        end else if (w_state_next == DONE) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_in_shift_ctrl.sv
// Directed bench for in_shift_ctrl (N1=102).
module tb_in_shift_ctrl;

    localparam int unsigned CW = 7;

    logic          i_clk;
    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic          i_ack;
    logic [CW-1:0] i_shift_len;
    logic          o_sel_shift;
    logic          o_sel_keep;
    logic          o_busy;
    logic          o_frame_valid;
    logic          o_done;
    logic [CW-1:0] o_bit_cnt;
`ifdef IN_SHIFT_CTRL_FRMCNT_EN
    logic [15:0]   o_frame_cnt;
`endif

    int errors = 0;
    int checks = 0;

    in_shift_ctrl dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_ack         (i_ack),
        .i_shift_len   (i_shift_len),
        .o_sel_shift   (o_sel_shift),
        .o_sel_keep    (o_sel_keep),
        .o_busy        (o_busy),
        .o_frame_valid (o_frame_valid),
        .o_done        (o_done),
        .o_bit_cnt     (o_bit_cnt)
`ifdef IN_SHIFT_CTRL_FRMCNT_EN
        ,
        .o_frame_cnt   (o_frame_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Count consecutive cycles in mode m (bounded), noting any BitCnt sequence break
    task automatic count_mode(input logic [1:0] m, output int n, output bit cnt_ok);
        n = 0;
        cnt_ok = 1'b1;
        while (({o_sel_shift, o_sel_keep} == m) && (n < 300)) begin
            if (o_bit_cnt !== CW'(n)) cnt_ok = 1'b0;
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ack = 1'b0; i_shift_len = '0;
        step(); step();
        checks++; if ({o_sel_shift, o_sel_keep} !== 2'b01) begin errors++; $display("FAIL reset_mode got=%b exp=01", {o_sel_shift, o_sel_keep}); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", o_frame_valid); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
        checks++; if (o_bit_cnt !== 7'd0) begin errors++; $display("FAIL reset_bitcnt got=%0d exp=0", o_bit_cnt); end
        i_rst = 1'b0;
        step();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_nominal();
        int n; bit ok;
        i_shift_len = 7'd6; i_start = 1'b1;
        step();
        i_start = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL nom_busy got=%b exp=1", o_busy); end
        count_mode(2'b00, n, ok);
        checks++; if (n !== 102) begin errors++; $display("FAIL nom_load_len got=%0d exp=102", n); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nom_load_cnt got=%b exp=1", ok); end
        checks++; if ({o_sel_shift, o_sel_keep, o_frame_valid} !== 3'b011) begin errors++; $display("FAIL nom_hold got=%b exp=011", {o_sel_shift, o_sel_keep, o_frame_valid}); end
        checks++; if (o_bit_cnt !== 7'd0) begin errors++; $display("FAIL nom_hold_cnt got=%0d exp=0", o_bit_cnt); end
        repeat (19) step();
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL nom_hold_wait got=%b exp=1", o_frame_valid); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL nom_fv_drop got=%b exp=0", o_frame_valid); end
        count_mode(2'b10, n, ok);
        checks++; if (n !== 6) begin errors++; $display("FAIL nom_shift_len got=%0d exp=6", n); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nom_shift_cnt got=%b exp=1", ok); end
        checks++; if ({o_done, o_busy, o_sel_shift, o_sel_keep} !== 4'b1101) begin errors++; $display("FAIL nom_done got=%b exp=1101", {o_done, o_busy, o_sel_shift, o_sel_keep}); end
        step();
        checks++; if ({o_done, o_busy} !== 2'b00) begin errors++; $display("FAIL nom_idle got=%b exp=00", {o_done, o_busy}); end
    endtask

    task automatic test_len_zero();
        int n; bit ok;
        i_shift_len = 7'd0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        count_mode(2'b00, n, ok);
        checks++; if (n !== 102) begin errors++; $display("FAIL z_load_len got=%0d exp=102", n); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        checks++; if ({o_done, o_sel_shift, o_sel_keep} !== 3'b101) begin errors++; $display("FAIL z_direct_done got=%b exp=101", {o_done, o_sel_shift, o_sel_keep}); end
        step();
        checks++; if ({o_done, o_busy, o_sel_shift} !== 3'b000) begin errors++; $display("FAIL z_idle got=%b exp=000", {o_done, o_busy, o_sel_shift}); end
    endtask

    task automatic test_len_clip();
        int n; bit ok;
        i_shift_len = 7'd127; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_shift_len = 7'd3;
        count_mode(2'b00, n, ok);
        checks++; if (n !== 101) begin errors++; $display("FAIL clip_load_len got=%0d exp=101", n); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        count_mode(2'b10, n, ok);
        checks++; if (n !== 102) begin errors++; $display("FAIL clip_shift_len got=%0d exp=102", n); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clip_shift_cnt got=%b exp=1", ok); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL clip_done got=%b exp=1", o_done); end
        step();
    endtask

    task automatic test_abort();
        int n; bit ok;
        i_shift_len = 7'd0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (50) step();
        checks++; if ({o_sel_shift, o_sel_keep, o_bit_cnt} !== {2'b00, 7'd50}) begin errors++; $display("FAIL ab_pre got=%b/%0d exp=00/50", {o_sel_shift, o_sel_keep}, o_bit_cnt); end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        checks++; if ({o_sel_shift, o_sel_keep, o_busy, o_done, o_frame_valid} !== 5'b01000) begin errors++; $display("FAIL ab_idle got=%b exp=01000", {o_sel_shift, o_sel_keep, o_busy, o_done, o_frame_valid}); end
        checks++; if (o_bit_cnt !== 7'd0) begin errors++; $display("FAIL ab_cnt got=%0d exp=0", o_bit_cnt); end
        step();
        checks++; if ({o_busy, o_done} !== 2'b00) begin errors++; $display("FAIL ab_nodone got=%b exp=00", {o_busy, o_done}); end
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        count_mode(2'b00, n, ok);
        checks++; if (n !== 102) begin errors++; $display("FAIL ab_reload_len got=%0d exp=102", n); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
        i_start = 1'b1; i_abort = 1'b1;
        step();
        i_start = 1'b0; i_abort = 1'b0;
        checks++; if ({o_busy, o_sel_shift, o_sel_keep} !== 3'b001) begin errors++; $display("FAIL ab_start_idle got=%b exp=001", {o_busy, o_sel_shift, o_sel_keep}); end
    endtask

    task automatic test_start_held();
        int n; bit ok;
        i_shift_len = 7'd2; i_start = 1'b1;
        step();
        count_mode(2'b00, n, ok);
        checks++; if (n !== 102) begin errors++; $display("FAIL held_load_len got=%0d exp=102", n); end
        i_ack = 1'b1;
        step();
        count_mode(2'b10, n, ok);
        checks++; if (n !== 2) begin errors++; $display("FAIL held_shift_len got=%0d exp=2", n); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL held_done got=%b exp=1", o_done); end
        step();
        checks++; if ({o_busy, o_sel_shift, o_sel_keep} !== 3'b001) begin errors++; $display("FAIL held_idle got=%b exp=001", {o_busy, o_sel_shift, o_sel_keep}); end
        step();
        checks++; if ({o_busy, o_sel_shift, o_sel_keep, o_bit_cnt} !== {3'b100, 7'd0}) begin errors++; $display("FAIL held_reload got=%b/%0d exp=100/0", {o_busy, o_sel_shift, o_sel_keep}, o_bit_cnt); end
        i_start = 1'b0; i_ack = 1'b0; i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL held_abort got=%b exp=0", o_busy); end
    endtask

    task automatic test_reset_mid();
        int n; bit ok;
        i_shift_len = 7'd6; i_start = 1'b1;
        step();
        i_start = 1'b0;
        count_mode(2'b00, n, ok);
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step(); step();
        checks++; if ({o_sel_shift, o_sel_keep, o_bit_cnt} !== {2'b10, 7'd2}) begin errors++; $display("FAIL rm_pre got=%b/%0d exp=10/2", {o_sel_shift, o_sel_keep}, o_bit_cnt); end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        checks++; if ({o_sel_shift, o_sel_keep, o_busy, o_frame_valid, o_done} !== 5'b01000) begin errors++; $display("FAIL rm_outputs got=%b exp=01000", {o_sel_shift, o_sel_keep, o_busy, o_frame_valid, o_done}); end
        checks++; if (o_bit_cnt !== 7'd0) begin errors++; $display("FAIL rm_cnt got=%0d exp=0", o_bit_cnt); end
        step();
    endtask

`ifdef IN_SHIFT_CTRL_FRMCNT_EN
    task automatic test_frame_cnt();
        int n; bit ok;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_shift_len = 7'd0;
        repeat (3) begin
            i_start = 1'b1;
            step();
            i_start = 1'b0;
            count_mode(2'b00, n, ok);
            i_ack = 1'b1;
            step();
            i_ack = 1'b0;
            step();
        end
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (10) step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        step();
        checks++; if (o_frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_cnt got=%0d exp=3", o_frame_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_len_zero();
        test_len_clip();
        test_abort();
        test_start_held();
        test_reset_mid();
`ifdef IN_SHIFT_CTRL_FRMCNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
